// File: rtl/iic_arb_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encoding, field widths
// and the default wait-state timeout.
package iic_arb_pkg;

    localparam int ADDR_W          = 8;
    localparam int REG_W           = 16;
    localparam int DATA_W          = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting at
// the pointer index, wrapping around, and returns the first active request
// as a one-hot grant together with its index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Walk N candidates from ptr upward; the first requester found wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid         = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_master_arbiter.sv
// Shares one I2C master among NUM_REQ requesters. A round-robin pick in IDLE
// latches the winner's command, pulses start_en, follows the master's busy
// handshake (bounded by a per-state timeout) and returns done/err/rdata to
// the granted requester.
module iic_master_arbiter
    import iic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rd_i,
    input  logic [NUM_REQ*ADDR_W-1:0] dev_addr_i,
    input  logic [NUM_REQ*REG_W-1:0]  reg_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      start_en,
    output logic                      wr_rd_flag,
    output logic [ADDR_W-1:0]         i2c_device_addr,
    output logic [REG_W-1:0]          register,
    output logic [DATA_W-1:0]         data_byte,
    input  logic                      busy,
    input  logic                      err,
    input  logic [DATA_W-1:0]         rd_byte
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t           state_reg, state_next;
    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [NUM_REQ-1:0]   gnt_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 err_flag_reg;
    logic [DATA_W-1:0]    rdata_reg;
    logic                 wr_rd_reg;
    logic [ADDR_W-1:0]    dev_reg;
    logic [REG_W-1:0]     regaddr_reg;
    logic [DATA_W-1:0]    wdata_reg;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 in_wait;
    logic                 timeout;
    logic                 complete;

    logic [ADDR_W-1:0]    dev_arr  [NUM_REQ];
    logic [REG_W-1:0]     reg_arr  [NUM_REQ];
    logic [DATA_W-1:0]    wdat_arr [NUM_REQ];

    // Unpack the flat per-requester command buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dev_arr[gi]  = dev_addr_i[gi*ADDR_W +: ADDR_W];
            assign reg_arr[gi]  = reg_addr_i[gi*REG_W +: REG_W];
            assign wdat_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_i),
        .ptr   (ptr_reg),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign in_wait  = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);
    assign timeout  = in_wait && (cnt_reg == CNT_LAST);
    assign complete = (state_reg == ST_COMPLETE);

    // Next-state logic; the timeout outranks the busy handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (pick_valid) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (timeout)   state_next = ST_COMPLETE;
                else if (busy) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (timeout || !busy) state_next = ST_COMPLETE;
            end
            ST_COMPLETE:  state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Wait-state cycle counter: restarts on every state change.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                      cnt_reg <= '0;
        else if (state_next != state_reg) cnt_reg <= '0;
        else if (in_wait)                cnt_reg <= cnt_reg + CNT_W'(1);
    end

    // Grant, command latch, sticky error, read capture and pointer update.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            gnt_reg      <= '0;
            idx_reg      <= '0;
            ptr_reg      <= '0;
            err_flag_reg <= 1'b0;
            rdata_reg    <= 8'h00;
            wr_rd_reg    <= 1'b0;
            dev_reg      <= 8'h00;
            regaddr_reg  <= 16'hFFFF;
            wdata_reg    <= 8'hFF;
        end else begin
            if (state_reg == ST_IDLE && pick_valid) begin
                gnt_reg      <= pick_gnt;
                idx_reg      <= pick_idx;
                err_flag_reg <= 1'b0;
                wr_rd_reg    <= rd_i[pick_idx];
                dev_reg      <= dev_arr[pick_idx];
                regaddr_reg  <= reg_arr[pick_idx];
                wdata_reg    <= wdat_arr[pick_idx];
            end
            if (in_wait && (err || timeout)) begin
                err_flag_reg <= 1'b1;
            end
            if (in_wait && state_next == ST_COMPLETE && wr_rd_reg) begin
                rdata_reg <= rd_byte;
            end
            if (complete) begin
                gnt_reg <= '0;
                ptr_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    assign gnt_o           = gnt_reg;
    assign done_o          = complete ? gnt_reg : '0;
    assign err_o           = (complete && err_flag_reg) ? gnt_reg : '0;
    assign rdata_o         = rdata_reg;
    assign start_en        = (state_reg == ST_START);
    assign wr_rd_flag      = wr_rd_reg;
    assign i2c_device_addr = dev_reg;
    assign register        = regaddr_reg;
    assign data_byte       = wdata_reg;

endmodule

// File: tb/tb_iic_master_arbiter.sv
// Bench for iic_master_arbiter: a transaction-level model predicts every
// output each cycle, and directed scenarios pin key values with literals.
// A second instance with a short timeout exercises the timeout path.
module tb_iic_master_arbiter;

    localparam int N       = 3;
    localparam int MAIN_TO = 100000;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [2:0]  req_i, rd_i;
    logic [23:0] dev_addr_i;
    logic [47:0] reg_addr_i;
    logic [23:0] wdata_i;
    logic        busy, err;
    logic [7:0]  rd_byte;
    logic [2:0]  gnt_o, done_o, err_o;
    logic [7:0]  rdata_o;
    logic        start_en, wr_rd_flag;
    logic [7:0]  i2c_device_addr;
    logic [15:0] register;
    logic [7:0]  data_byte;

    logic [2:0]  t_req;
    logic        t_busy, t_err_in;
    logic [2:0]  t_gnt, t_done, t_err;
    logic [7:0]  t_rdata;
    logic        t_start, t_wr_rd;
    logic [7:0]  t_dev;
    logic [15:0] t_reg;
    logic [7:0]  t_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    iic_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(MAIN_TO)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .req_i(req_i), .rd_i(rd_i),
        .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .start_en(start_en), .wr_rd_flag(wr_rd_flag),
        .i2c_device_addr(i2c_device_addr), .register(register),
        .data_byte(data_byte), .busy(busy), .err(err), .rd_byte(rd_byte)
    );

    iic_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut_to (
        .clk_i(clk_i), .rst_n(rst_n), .req_i(t_req), .rd_i(rd_i),
        .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wdata_i(wdata_i),
        .gnt_o(t_gnt), .done_o(t_done), .err_o(t_err), .rdata_o(t_rdata),
        .start_en(t_start), .wr_rd_flag(t_wr_rd),
        .i2c_device_addr(t_dev), .register(t_reg),
        .data_byte(t_data), .busy(t_busy), .err(t_err_in), .rd_byte(rd_byte)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_owner: requester currently served (-1 none); m_t: 0 in the start
    // cycle, 1 afterwards; m_pt: cycles spent in the current master phase;
    // m_up: master busy has been seen; m_fin: this is the completion cycle.
    int          m_owner, m_t, m_pt, m_ptr;
    bit          m_up, m_fin, m_err, m_rd;
    logic [7:0]  m_dev, m_data, m_rdata;
    logic [15:0] m_reg;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1; m_t <= 0; m_pt <= 0; m_ptr <= 0;
            m_up <= 0; m_fin <= 0; m_err <= 0; m_rd <= 0;
            m_dev <= 8'h00; m_data <= 8'hFF; m_rdata <= 8'h00; m_reg <= 16'hFFFF;
        end else if (m_fin) begin
            m_ptr   <= (m_owner + 1) % N;
            m_owner <= -1;
            m_fin   <= 0;
        end else if (m_owner < 0) begin : arb
            int w;
            int c;
            w = -1;
            c = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (w < 0 && req_i[c]) w = c;
            end
            if (w >= 0) begin
                m_owner <= w; m_t <= 0; m_err <= 0;
                m_rd   <= rd_i[w];
                m_dev  <= dev_addr_i[w*8 +: 8];
                m_reg  <= reg_addr_i[w*16 +: 16];
                m_data <= wdata_i[w*8 +: 8];
            end
        end else if (m_t == 0) begin
            m_t <= 1; m_pt <= 0; m_up <= 0;
        end else begin
            if (err) m_err <= 1;
            if (m_pt == MAIN_TO - 1) begin
                m_fin <= 1; m_err <= 1;
                if (m_rd) m_rdata <= rd_byte;
            end else if (!m_up && busy) begin
                m_up <= 1; m_pt <= 0;
            end else if (m_up && !busy) begin
                m_fin <= 1;
                if (m_rd) m_rdata <= rd_byte;
            end else begin
                m_pt <= m_pt + 1;
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk_i) begin
        logic [2:0] oh;
        if (chk_en) begin
            oh = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            check("m_gnt",   gnt_o, oh);
            check("m_start", start_en, (m_owner >= 0 && m_t == 0) ? 1'b1 : 1'b0);
            check("m_done",  done_o, m_fin ? oh : 3'b000);
            check("m_err",   err_o, (m_fin && m_err) ? oh : 3'b000);
            check("m_rdata", rdata_o, m_rdata);
            check("m_wrrd",  wr_rd_flag, m_rd);
            check("m_dev",   i2c_device_addr, m_dev);
            check("m_reg",   register, m_reg);
            check("m_data",  data_byte, m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_start(output int at);
        int n;
        n = 0;
        while (!start_en && n < 100) begin step(); n++; end
        check("start_seen", start_en, 1'b1);
        at = cyc;
    endtask

    task automatic wait_done(output int at);
        int n;
        n = 0;
        while (done_o == 3'b000 && n < 200) begin step(); n++; end
        check("done_seen", (done_o != 3'b000), 1'b1);
        at = cyc;
    endtask

    // Called in the START cycle: busy rises after dly cycles, stays high for
    // len cycles, err pulses at offset epos (negative: none).
    task automatic run_master(input int dly, input int len, input int epos, input logic [7:0] rb);
        rd_byte = rb;
        repeat (dly) step();
        busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            err = (i == epos);
            step();
        end
        busy = 1'b0;
        err  = 1'b0;
    endtask

    logic [2:0] exp_rr [4];
    int s_at, d_at, prev_d, r_at;

    initial begin
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
        rst_n = 1'b0; req_i = '0; rd_i = '0; busy = 0; err = 0; rd_byte = 8'h00;
        t_req = '0; t_busy = 0; t_err_in = 0;
        dev_addr_i = {8'h33, 8'h22, 8'h11};
        reg_addr_i = {16'hC003, 16'hB002, 16'hA001};
        wdata_i    = {8'hE3, 8'hE2, 8'hE1};
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_gnt", gnt_o, 3'b000);
        check("rst_start", start_en, 1'b0);
        check("rst_reg", register, 16'hFFFF);
        check("rst_data", data_byte, 8'hFF);
        check("rst_dev", i2c_device_addr, 8'h00);
        rst_n = 1'b1;
        step();

        // Round robin with all three requesting, pointer starting at 0.
        req_i = 3'b111;
        prev_d = 0;
        for (int j = 0; j < 4; j++) begin
            wait_start(s_at);
            $display("[TB] rr txn %0d: gnt=%b at cycle %0d", j, gnt_o, s_at);
            check("rr_gnt", gnt_o, exp_rr[j]);
            if (j > 0) check("rr_gap", s_at - prev_d, 2);
            run_master(1, 3, -1, 8'h00);
            wait_done(d_at);
            check("rr_done", done_o, exp_rr[j]);
            prev_d = d_at;
        end
        req_i = 3'b000;
        step();

        // Single write from requester 1, busy high for 50 cycles.
        dev_addr_i[15:8]  = 8'h7A;
        reg_addr_i[31:16] = 16'h3014;
        wdata_i[15:8]     = 8'h05;
        rd_i  = 3'b000;
        req_i = 3'b010;
        r_at  = cyc;
        wait_start(s_at);
        $display("[TB] write r1: gnt=%b dev=%h reg=%h data=%h", gnt_o, i2c_device_addr, register, data_byte);
        check("wr_latency", s_at - r_at, 1);
        check("wr_gnt", gnt_o, 3'b010);
        check("wr_dev", i2c_device_addr, 8'h7A);
        check("wr_reg", register, 16'h3014);
        check("wr_data", data_byte, 8'h05);
        check("wr_dir", wr_rd_flag, 1'b0);
        run_master(1, 50, -1, 8'h00);
        wait_done(d_at);
        $display("[TB] write r1: done=%b err=%b after %0d cycles", done_o, err_o, d_at - s_at);
        check("wr_span", d_at - s_at, 52);
        check("wr_done", done_o, 3'b010);
        check("wr_err", err_o, 3'b000);
        check("wr_hold_dev", i2c_device_addr, 8'h7A);
        req_i = 3'b000;
        step();

        // Read from requester 2 returning A5.
        rd_i  = 3'b100;
        req_i = 3'b100;
        wait_start(s_at);
        run_master(2, 5, -1, 8'hA5);
        wait_done(d_at);
        $display("[TB] read r2: done=%b rdata=%h err=%b", done_o, rdata_o, err_o);
        check("rd_done", done_o, 3'b100);
        check("rd_data", rdata_o, 8'hA5);
        check("rd_err", err_o, 3'b000);
        req_i = 3'b000; rd_i = 3'b000;
        step();

        // Master error pulse in WAIT_DONE, then a clean transaction.
        req_i = 3'b001;
        wait_start(s_at);
        run_master(1, 6, 3, 8'h00);
        wait_done(d_at);
        $display("[TB] err txn: done=%b err=%b", done_o, err_o);
        check("err_set", err_o, 3'b001);
        req_i = 3'b000;
        step();
        req_i = 3'b001;
        wait_start(s_at);
        run_master(1, 4, -1, 8'h00);
        wait_done(d_at);
        $display("[TB] clean txn: done=%b err=%b", done_o, err_o);
        check("err_clear", err_o, 3'b000);
        req_i = 3'b000;
        step();

        // Reset in WAIT_DONE, then index 2 alone after release.
        req_i = 3'b010;
        wait_start(s_at);
        step();
        busy = 1'b1;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        $display("[TB] async reset: gnt=%b done=%b reg=%h", gnt_o, done_o, register);
        check("ar_gnt", gnt_o, 3'b000);
        check("ar_done", done_o, 3'b000);
        check("ar_err", err_o, 3'b000);
        check("ar_start", start_en, 1'b0);
        check("ar_rdata", rdata_o, 8'h00);
        check("ar_dir", wr_rd_flag, 1'b0);
        check("ar_dev", i2c_device_addr, 8'h00);
        check("ar_reg", register, 16'hFFFF);
        check("ar_data", data_byte, 8'hFF);
        busy = 1'b0; req_i = 3'b000;
        step();
        rst_n = 1'b1;
        req_i = 3'b100;
        wait_start(s_at);
        $display("[TB] after reset: gnt=%b", gnt_o);
        check("ar_gnt2", gnt_o, 3'b100);
        run_master(1, 3, -1, 8'h00);
        wait_done(d_at);
        req_i = 3'b000;
        step();

        // Timeout instance: busy never rises.
        t_req = 3'b001;
        begin
            int n;
            n = 0;
            while (!t_start && n < 100) begin step(); n++; end
            check("to_start_seen", t_start, 1'b1);
            s_at = cyc;
            n = 0;
            while (t_done == 3'b000 && n < 100) begin step(); n++; end
            d_at = cyc;
        end
        $display("[TB] timeout: done=%b err=%b after %0d cycles", t_done, t_err, d_at - s_at);
        check("to_span", d_at - s_at, 17);
        check("to_done", t_done, 3'b001);
        check("to_err", t_err, 3'b001);
        t_req = 3'b000;
        step();
        check("to_idle_gnt", t_gnt, 3'b000);
        check("to_idle_done", t_done, 3'b000);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iic_master_arbiter.md
IIC_MASTER_ARBITER -- requirements
Module: iic_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing one I2C master.
REQ-002 Parameter TIMEOUT_CYC, default 100000, maximum clk_i cycles allowed per wait state.
REQ-003 clk_i  input  1  system clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  NUM_REQ  per-requester transaction request; held high until matching done_o.
REQ-006 rd_i  input  NUM_REQ  per-requester direction: 0 write, 1 read.
REQ-007 dev_addr_i  input  NUM_REQ*8  per-requester device address, requester k at bits [8k+7:8k].
REQ-008 reg_addr_i  input  NUM_REQ*16  per-requester register address.
REQ-009 wdata_i  input  NUM_REQ*8  per-requester write data byte.
REQ-010 gnt_o  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-011 done_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 err_o  output  NUM_REQ  error status, valid only with done_o.
REQ-013 rdata_o  output  8  read byte, valid with done_o of a read.
REQ-014 start_en  output  1  one-cycle start pulse to the I2C master.
REQ-015 wr_rd_flag  output  1  direction to the master: 0 write, 1 read.
REQ-016 i2c_device_addr, register, data_byte  output  8/16/8  command to the master, stable from start_en until done_o.
REQ-017 busy, err  input  1 each  master status; rd_byte  input  8  master read data.

Function
REQ-018 FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE -> START when any req_i is high.
- START -> WAIT_BUSY unconditionally.
- WAIT_BUSY -> WAIT_DONE when busy=1.
- WAIT_DONE -> COMPLETE when busy=0.
- COMPLETE -> IDLE unconditionally.
REQ-019 Arbitration happens in IDLE, round-robin.
- Search starts at the index after the last granted requester; after reset it starts at index 0.
- The winner is the first requester found with req_i high.
REQ-020 On IDLE->START: gnt_o is loaded one-hot, and the winner's fields are latched into wr_rd_flag, i2c_device_addr, register and data_byte.
REQ-021 start_en is high exactly during the START cycle, one cycle after the requesting edge is sampled.
REQ-022 A master err=1 sampled in WAIT_BUSY or WAIT_DONE sets a sticky error flag; the flag clears on entry to START.
REQ-023 A counter runs in WAIT_BUSY and WAIT_DONE and clears on every state entry. When it reaches TIMEOUT_CYC-1, the FSM goes to COMPLETE with the error flag set.
REQ-024 In COMPLETE, for the granted index only:
- done_o pulses for one cycle;
- err_o equals the error flag;
- rdata_o captures rd_byte on a read.
REQ-025 gnt_o clears on COMPLETE->IDLE; the round-robin pointer updates on the same edge.
REQ-026 Deasserting req_i mid-transaction does not abort; the transaction completes and done_o still pulses.
REQ-027 Requests that are new or still held during COMPLETE are arbitrated only in the following IDLE cycle, giving a minimum of one IDLE cycle between transactions.
REQ-028 busy already high in START is ignored; WAIT_BUSY still requires busy=1 before moving to WAIT_DONE.
REQ-029 Master-side command outputs hold their last values outside transactions.

Reset
REQ-030 Asynchronous reset, including reset mid-transaction, forces:
- state IDLE, pointer 0, counter 0, error flag 0;
- gnt_o 0, done_o 0, err_o 0, start_en 0;
- rdata_o 8'h00, wr_rd_flag 0, i2c_device_addr 8'h00, register 16'hFFFF, data_byte 8'hFF.
REQ-031 After rst_n rises, the first arbitration uses index 0 first.

Structure
REQ-032 Package iic_arb_pkg holds:
- the state encoding;
- ADDR_W=8, REG_W=16, DATA_W=8;
- the default TIMEOUT_CYC.
REQ-033 Sub-module rr_arbiter: combinational round-robin one-hot picker taking req and pointer inputs. The FSM and the datapath stay in iic_master_arbiter.

Verification
REQ-034 Single write, requester 1 (dev 8'h7A, reg 16'h3014, data 8'h05); master busy high for 50 cycles.
- gnt_o=3'b010 and start_en pulses one cycle after req.
- Outputs are stable until done_o[1]; err_o[1]=0.
REQ-035 req_i=3'b111 held, pointer 0.
- Grants go 001, 010, 100, 001, each separated by at least one IDLE cycle.
REQ-036 Read by requester 2, rd_byte=8'hA5 when busy falls.
- done_o[2]=1, rdata_o=8'hA5, err_o[2]=0.
REQ-037 TIMEOUT_CYC=16 and busy never rises.
- done_o and err_o for the granted index pulse 17 cycles after start_en; the FSM returns to IDLE.
REQ-038 err pulse during WAIT_DONE, then busy falls.
- err_o=1 with done_o.
- The next transaction reports err_o=0.
REQ-039 rst_n low while in WAIT_DONE.
- All outputs go to reset values immediately.
- After release, a request from index 2 alone is granted.
